// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the multiply/divide controller: the md_op_t
//   operation encoding seen on the op port, the controller state enum and
//   the default busy latencies.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MADD  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/md_div_core.sv
// md_div_core
//   Combinational 32-bit divider for the muldiv controller.
//   Signed division truncates toward zero; the remainder takes the sign of
//   the dividend. A zero divisor raises div_zero, and the quotient and
//   remainder are then don't-care.
// Ports:
//   dividend  in  32  numerator (rs)
//   divisor   in  32  denominator (rt)
//   is_signed in   1  1 = DIV, 0 = DIVU
//   quot      out 32  quotient
//   rem       out 32  remainder
//   div_zero  out  1  divisor is zero
module md_div_core (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Work on magnitudes so that signed and unsigned share one divider and
  // the truncate-toward-zero behaviour falls out of the sign fix-up.
  always_comb begin
    neg_a    = is_signed & dividend[31];
    neg_b    = is_signed & divisor[31];
    mag_a    = neg_a ? (32'd0 - dividend) : dividend;
    mag_b    = neg_b ? (32'd0 - divisor) : divisor;
    div_zero = (divisor == 32'd0);
    // Keep the divider free of X when the divisor is zero; result is unused.
    safe_b   = div_zero ? 32'd1 : mag_b;
    q_mag    = mag_a / safe_b;
    r_mag    = mag_a % safe_b;
    quot     = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem      = neg_a ? (32'd0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   HI/LO multiply/divide unit controller. Results are computed at start,
//   held in a private result register, and committed to hi/lo after the
//   configured number of busy cycles.
//   Optional feature macro: MULDIV_MADD_EN enables MADD ({hi,lo} += rs*rt,
//   signed); without it MADD behaves as NONE.
// Ports:
//   clk     in   1  rising-edge clock
//   reset   in   1  asynchronous, active-low reset
//   start   in   1  E-stage md operation valid
//   op      in   3  md_op_t operation code
//   rs_val  in  32  forwarded rs operand
//   rt_val  in  32  forwarded rt operand
//   d_md    in   1  D-stage instruction is md-class
//   busy    out  1  multi-cycle operation in progress
//   stall   out  1  freeze D stage
//   hi      out 32  HI register
//   lo      out 32  LO register
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | accepting operations; MTHI/MTLO write directly
// ST_MUL  | multiply/MADD result held, counting down
// ST_DIV  | divide result held, counting down
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      res_q, res_d;
  logic             wr_q, wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        is_mul;
  logic        is_div;
  logic [63:0] mul_res;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        div_zero;

  md_div_core u_div (
    .dividend  (rs_val),
    .divisor   (rt_val),
    .is_signed (op == OP_DIV),
    .quot      (div_quot),
    .rem       (div_rem),
    .div_zero  (div_zero)
  );

  always_comb begin
`ifdef MULDIV_MADD_EN
    is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD);
`else
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
    is_div = (op == OP_DIV) || (op == OP_DIVU);
  end

  always_comb begin
    logic signed [63:0] prod_s;
    prod_s  = $signed(rs_val) * $signed(rt_val);
    mul_res = prod_s;
    if (op == OP_MULTU) begin
      mul_res = {32'd0, rs_val} * {32'd0, rt_val};
    end
`ifdef MULDIV_MADD_EN
    // Accumulator is the architectural hi/lo as they stand at start.
    if (op == OP_MADD) begin
      mul_res = $signed({hi_q, lo_q}) + prod_s;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul) begin
            res_d   = mul_res;
            wr_d    = 1'b1;
            cnt_d   = CNT_W'(MUL_LAT);
            state_d = ST_MUL;
          end else if (is_div) begin
            res_d   = {div_rem, div_quot};
            // Divide by zero still occupies the unit but never commits.
            wr_d    = ~div_zero;
            cnt_d   = CNT_W'(DIV_LAT);
            state_d = ST_DIV;
          end else if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          wr_d    = 1'b0;
          if (wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  // Gated by reset so the D stage is never frozen while the unit is held.
  assign stall = reset & d_md & (busy | (start & (is_mul | is_div)));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_pass = 0;

  muldiv_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .d_md   (d_md),
    .busy   (busy),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one op, then follow it through its busy window checking busy and
  // stall each cycle, then check the committed hi/lo.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic dmd, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; d_md = dmd;
    #1 chk({tag, "_stall_start"}, 64'(stall), 64'(dmd && lat > 0));
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_stall_busy"}, 64'(stall), 64'(dmd));
      @(negedge clk);
    end
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_stall_end"}, 64'(stall), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    d_md = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4; d_md = 1'b1;
    #12;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    start = 1'b0; op = OP_NONE; d_md = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    run_op("mult",   OP_MULT,  32'd3,        32'hFFFFFFFE, 1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu",  OP_MULTU, 32'hFFFFFFFF, 32'd2,        1'b0, 5,  32'h00000001, 32'hFFFFFFFE);
    run_op("mult_nn", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5,  32'h00000000, 32'h00000001);
    run_op("div",    OP_DIV,   32'hFFFFFFF9, 32'd2,        1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_z", OP_DIVU,  32'd7,        32'd0,        1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_pn", OP_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu",   OP_DIVU,  32'hFFFFFFFF, 32'h10,       1'b0, 10, 32'h0000000F, 32'h0FFFFFFF);
    run_op("none",   OP_NONE,  32'h1234,     32'h5678,     1'b1, 0,  32'h0000000F, 32'h0FFFFFFF);
    run_op("mthi",   OP_MTHI,  32'd0,        32'h5555,     1'b1, 0,  32'h00000000, 32'h0FFFFFFF);
    run_op("mtlo",   OP_MTLO,  32'd1,        32'h5555,     1'b1, 0,  32'h00000000, 32'h00000001);
`ifdef MULDIV_MADD_EN
    run_op("madd",   OP_MADD,  32'd2,        32'd3,        1'b1, 5,  32'h00000000, 32'h00000007);
`else
    run_op("madd_off", OP_MADD, 32'd2,       32'd3,        1'b1, 0,  32'h00000000, 32'h00000001);
`endif

    // start during busy must be ignored (an MTHI here would otherwise land)
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    op = OP_MTHI; rs_val = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    chk("ign_hi_mid", 64'(hi), 64'h0);
    repeat (4) @(negedge clk);
    chk("ign_busy_end", 64'(busy), 64'd0);
    chk("ign_hi", 64'(hi), 64'h0);
    chk("ign_lo", 64'(lo), 64'd6);

    // reset in the fourth busy cycle of a divide
    @(negedge clk);
    start = 1'b1; op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    repeat (3) @(negedge clk);
    chk("rdiv_busy_pre", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("rdiv_busy", 64'(busy), 64'd0);
    chk("rdiv_hi", 64'(hi), 64'd0);
    chk("rdiv_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("rdiv_busy_late", 64'(busy), 64'd0);
    chk("rdiv_hi_late", 64'(hi), 64'd0);
    chk("rdiv_lo_late", 64'(lo), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
